// File: rtl/game_pkg.sv
// game_pkg: state encodings, field widths and the volume step helper shared
// by game_ctrl, the LED display block and any other consumer of game state.
package game_pkg;

   localparam int STATE_W = 3;
   localparam int HP_W    = 3;
   localparam int VOL_W   = 3;

   localparam logic [STATE_W-1:0] INIT = 3'b000;
   localparam logic [STATE_W-1:0] WAIT = 3'b001;
   localparam logic [STATE_W-1:0] GAME = 3'b010;
   localparam logic [STATE_W-1:0] WIN  = 3'b011;
   localparam logic [STATE_W-1:0] LOSE = 3'b100;

   typedef enum logic [STATE_W-1:0] {
      ST_INIT = INIT,
      ST_WAIT = WAIT,
      ST_GAME = GAME,
      ST_WIN  = WIN,
      ST_LOSE = LOSE
   } state_e;

   // One volume step: saturates at 0 and vmax; simultaneous up/down cancel.
   function automatic logic [VOL_W-1:0] vol_step(input logic [VOL_W-1:0] v,
                                                 input logic up,
                                                 input logic dn,
                                                 input logic [VOL_W-1:0] vmax);
      logic [VOL_W-1:0] r;
      r = v;
      if (up && !dn && v < vmax) r = v + 1'b1;
      if (dn && !up && v != '0)  r = v - 1'b1;
      return r;
   endfunction

endpackage

// File: rtl/hsec_divider.sv
// hsec_divider: free-running half-second timebase. hsec_tick is high for the
// cycle in which the counter sits at HSEC_CYCLES-1; div_hsec flips after it.
module hsec_divider #(
   parameter int HSEC_CYCLES = 50000000
) (
   input  logic clk,
   input  logic rst,
   output logic hsec_tick,
   output logic div_hsec
);

   localparam int CNT_W = $clog2(HSEC_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HSEC_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(HSEC_CYCLES - 2);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tick_q;
   logic             div_q;

   // Next counter value: wrap from HSEC_CYCLES-1 back to 0.
   always_comb begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
   end

   // Tick is registered one count early so it lines up with CNT_LAST.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
         div_q  <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         tick_q <= (cnt_q == CNT_PRE);
         if (tick_q) div_q <= ~div_q;
      end
   end

   assign hsec_tick = tick_q;
   assign div_hsec  = div_q;

endmodule

// File: rtl/game_ctrl.sv
// game_ctrl: INIT->WAIT->GAME->WIN/LOSE sequencer with HP, volume and the
// half-second timebase. Optional pause in GAME when GAME_CTRL_PAUSE_EN is
// defined (adds the btn_pause input); otherwise paused stays 0.
module game_ctrl
   import game_pkg::*;
#(
   parameter int HSEC_CYCLES = 50000000,
   parameter int START_HP    = 7,
   parameter int VOL_INIT    = 3,
   parameter int VOL_MAX     = 5,
   parameter int WAIT_HSEC   = 6,
   parameter int GAME_HSEC   = 120,
   parameter int RESULT_HSEC = 10
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               btn_start,
   input  logic               btn_vol_up,
   input  logic               btn_vol_down,
   input  logic               hit,
   input  logic               goal,
`ifdef GAME_CTRL_PAUSE_EN
   input  logic               btn_pause,
`endif
   output logic [STATE_W-1:0] state,
   output logic [HP_W-1:0]    curr_hp,
   output logic [VOL_W-1:0]   volume,
   output logic               div_hsec,
   output logic               hsec_tick,
   output logic               paused
);

   localparam logic [7:0]       WAIT_LAST   = 8'(WAIT_HSEC - 1);
   localparam logic [7:0]       GAME_LAST   = 8'(GAME_HSEC - 1);
   localparam logic [7:0]       RESULT_LAST = 8'(RESULT_HSEC - 1);
   localparam logic [HP_W-1:0]  HP_START    = HP_W'(START_HP);
   localparam logic [VOL_W-1:0] VOL_RST     = VOL_W'(VOL_INIT);
   localparam logic [VOL_W-1:0] VOL_CEIL    = VOL_W'(VOL_MAX);

   state_e            state_q;
   logic [HP_W-1:0]   hp_q;
   logic [VOL_W-1:0]  vol_q;
   logic [7:0]        hcnt_q;
   logic              paused_q;
   logic              tick;
   logic              pause_btn;

`ifdef GAME_CTRL_PAUSE_EN
   assign pause_btn = btn_pause;
`else
   assign pause_btn = 1'b0;
`endif

   hsec_divider #(
      .HSEC_CYCLES(HSEC_CYCLES)
   ) u_div (
      .clk      (clk),
      .rst      (rst),
      .hsec_tick(tick),
      .div_hsec (div_hsec)
   );

   // Game flow: state, HP, phase counter and pause; hcnt clears on every state change.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_INIT;
         hp_q     <= '0;
         hcnt_q   <= '0;
         paused_q <= 1'b0;
      end else begin
         case (state_q)
            ST_INIT: begin
               if (btn_start) begin
                  state_q <= ST_WAIT;
                  hcnt_q  <= '0;
               end
            end
            ST_WAIT: begin
               if (tick) begin
                  if (hcnt_q == WAIT_LAST) begin
                     state_q <= ST_GAME;
                     hp_q    <= HP_START;
                     hcnt_q  <= '0;
                  end else begin
                     hcnt_q <= hcnt_q + 8'd1;
                  end
               end
            end
            ST_GAME: begin
               if (pause_btn) paused_q <= ~paused_q;
               if (!paused_q) begin
                  if (hit && hp_q == HP_W'(1)) begin
                     // Losing the last HP beats a simultaneous goal or timeout.
                     state_q  <= ST_LOSE;
                     hp_q     <= '0;
                     hcnt_q   <= '0;
                     paused_q <= 1'b0;
                  end else begin
                     if (hit && hp_q != '0) hp_q <= hp_q - 1'b1;
                     if (goal || (tick && hcnt_q == GAME_LAST)) begin
                        state_q  <= ST_WIN;
                        hcnt_q   <= '0;
                        paused_q <= 1'b0;
                     end else if (tick) begin
                        hcnt_q <= hcnt_q + 8'd1;
                     end
                  end
               end
            end
            ST_WIN, ST_LOSE: begin
               if (tick) begin
                  if (hcnt_q == RESULT_LAST) begin
                     state_q <= ST_INIT;
                     hp_q    <= '0;
                     hcnt_q  <= '0;
                  end else begin
                     hcnt_q <= hcnt_q + 8'd1;
                  end
               end
            end
            default: begin
               state_q  <= ST_INIT;
               hp_q     <= '0;
               hcnt_q   <= '0;
               paused_q <= 1'b0;
            end
         endcase
      end
   end

   // Volume responds in every state, including while paused.
   always_ff @(posedge clk) begin
      if (rst) vol_q <= VOL_RST;
      else     vol_q <= vol_step(vol_q, btn_vol_up, btn_vol_down, VOL_CEIL);
   end

   assign state     = state_q;
   assign curr_hp   = hp_q;
   assign volume    = vol_q;
   assign hsec_tick = tick;
   assign paused    = paused_q;

endmodule

// File: tb/tb_game_ctrl.sv
// tb_game_ctrl: directed steps followed by random pulses, all checked each
// cycle against a time-based model of the game rules.
module tb_game_ctrl;

   localparam int H   = 4;
   localparam int WH  = 2;
   localparam int GH  = 8;
   localparam int RH  = 2;
   localparam int SHP = 3;
   localparam int VI  = 3;
   localparam int VM  = 5;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       btn_start = 1'b0, btn_vol_up = 1'b0, btn_vol_down = 1'b0;
   logic       hit = 1'b0, goal = 1'b0, btn_pause = 1'b0;
   logic [2:0] state, curr_hp, volume;
   logic       div_hsec, hsec_tick, paused;

   int checks = 0;
   int errors = 0;

   // model: m_k = cycles since reset release, m_h = half-seconds in current phase
   int m_state, m_hp, m_vol, m_k, m_h;
   bit m_paused;

   always #5 clk = ~clk;

   game_ctrl #(
      .HSEC_CYCLES(H), .START_HP(SHP), .VOL_INIT(VI), .VOL_MAX(VM),
      .WAIT_HSEC(WH), .GAME_HSEC(GH), .RESULT_HSEC(RH)
   ) dut (
      .clk(clk), .rst(rst), .btn_start(btn_start),
      .btn_vol_up(btn_vol_up), .btn_vol_down(btn_vol_down),
      .hit(hit), .goal(goal),
`ifdef GAME_CTRL_PAUSE_EN
      .btn_pause(btn_pause),
`endif
      .state(state), .curr_hp(curr_hp), .volume(volume),
      .div_hsec(div_hsec), .hsec_tick(hsec_tick), .paused(paused)
   );

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_step();
      bit tick, pz, pb;
      int ns;
      if (rst) begin
         m_state = 0; m_hp = 0; m_vol = VI; m_k = 0; m_h = 0; m_paused = 0;
         return;
      end
`ifdef GAME_CTRL_PAUSE_EN
      pb = btn_pause;
`else
      pb = 1'b0;
`endif
      tick = ((m_k % H) == H - 1);
      ns = m_state;
      case (m_state)
         0: if (btn_start) ns = 1;
         1: if (tick) begin
               if (m_h == WH - 1) begin ns = 2; m_hp = SHP; end
               else m_h++;
            end
         2: begin
               pz = m_paused;
               if (pb) m_paused = !m_paused;
               if (!pz) begin
                  if (hit && m_hp == 1) begin
                     ns = 4; m_hp = 0;
                  end else begin
                     if (hit && m_hp > 0) m_hp--;
                     if (goal) ns = 3;
                     else if (tick) begin
                        if (m_h == GH - 1) ns = 3;
                        else m_h++;
                     end
                  end
               end
            end
         default: if (tick) begin
               if (m_h == RH - 1) begin ns = 0; m_hp = 0; end
               else m_h++;
            end
      endcase
      if (ns != m_state) begin m_h = 0; m_paused = 0; end
      m_state = ns;
      if (btn_vol_up && !btn_vol_down && m_vol < VM) m_vol++;
      if (btn_vol_down && !btn_vol_up && m_vol > 0) m_vol--;
      m_k++;
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
      chk("state", 8'(state), 8'(m_state));
      chk("curr_hp", 8'(curr_hp), 8'(m_hp));
      chk("volume", 8'(volume), 8'(m_vol));
      chk("hsec_tick", 8'(hsec_tick), 8'((m_k % H) == H - 1));
      chk("div_hsec", 8'(div_hsec), 8'((m_k / H) % 2));
      chk("paused", 8'(paused), 8'(m_paused));
      btn_start = 0; btn_vol_up = 0; btn_vol_down = 0;
      hit = 0; goal = 0; btn_pause = 0;
   endtask

   task automatic wait_state(input int target, input int budget);
      int n = 0;
      while (m_state != target && n < budget) begin
         cycle();
         n++;
      end
      chk("wait_state", 8'(state), 8'(target));
   endtask

   task automatic do_reset();
      rst = 1;
      cycle();
      cycle();
      rst = 0;
   endtask

   initial begin
      // reset and aligned start: WAIT lasts exactly 8 cycles
      do_reset();
      chk("rst_state", 8'(state), 8'd0);
      chk("rst_vol", 8'(volume), 8'd3);
      repeat (3) cycle();
      btn_start = 1; cycle();
      chk("start_wait", 8'(state), 8'd1);
      repeat (7) cycle();
      chk("still_wait", 8'(state), 8'd1);
      cycle();
      chk("enter_game", 8'(state), 8'd2);
      chk("start_hp", 8'(curr_hp), 8'd3);

      // three hits -> LOSE
      hit = 1; cycle(); chk("hit1", 8'(curr_hp), 8'd2);
      cycle();
      hit = 1; cycle(); chk("hit2", 8'(curr_hp), 8'd1);
      hit = 1; cycle(); chk("lose", 8'(state), 8'd4);
      chk("lose_hp", 8'(curr_hp), 8'd0);
      wait_state(0, 20);

      // survive to timeout -> WIN
      btn_start = 1; cycle();
      wait_state(2, 20);
      wait_state(3, GH * H + 8);
      wait_state(0, 20);

      // hit+goal on last HP -> LOSE
      btn_start = 1; cycle();
      wait_state(2, 20);
      hit = 1; cycle();
      hit = 1; cycle();
      hit = 1; goal = 1; cycle();
      chk("hitgoal_lose", 8'(state), 8'd4);
      wait_state(0, 20);

      // hit+goal with HP left -> WIN with decremented HP
      btn_start = 1; cycle();
      wait_state(2, 20);
      hit = 1; goal = 1; cycle();
      chk("hitgoal_win", 8'(state), 8'd3);
      chk("hitgoal_hp", 8'(curr_hp), 8'd2);
      wait_state(0, 20);

      // volume saturation
      do_reset();
      repeat (3) begin btn_vol_up = 1; cycle(); end
      chk("vol_max", 8'(volume), 8'd5);
      repeat (6) begin btn_vol_down = 1; cycle(); end
      chk("vol_min", 8'(volume), 8'd0);
      btn_vol_up = 1; btn_vol_down = 1; cycle();
      chk("vol_both", 8'(volume), 8'd0);

      // reset mid-game
      btn_start = 1; cycle();
      wait_state(2, 20);
      hit = 1; cycle();
      cycle();
      rst = 1; cycle(); rst = 0;
      chk("midrst_state", 8'(state), 8'd0);
      chk("midrst_hp", 8'(curr_hp), 8'd0);
      chk("midrst_vol", 8'(volume), 8'd3);
      chk("midrst_div", 8'(div_hsec), 8'd0);

`ifdef GAME_CTRL_PAUSE_EN
      // pause holds the game through 20 ticks and blocks hits
      btn_start = 1; cycle();
      wait_state(2, 20);
      btn_pause = 1; cycle();
      chk("pause_on", 8'(paused), 8'd1);
      repeat (20 * H) cycle();
      chk("pause_hold", 8'(state), 8'd2);
      hit = 1; cycle();
      chk("pause_hit_state", 8'(state), 8'd2);
      chk("pause_hit_hp", 8'(curr_hp), 8'd3);
      btn_pause = 1; cycle();
      chk("pause_off", 8'(paused), 8'd0);
      wait_state(3, GH * H + 8);
      wait_state(0, 20);
`endif

      // random pulses against the model
      for (int i = 0; i < 3000; i++) begin
         rst          = ($urandom_range(0, 599) == 0);
         btn_start    = ($urandom_range(0, 15) == 0);
         btn_vol_up   = ($urandom_range(0, 7) == 0);
         btn_vol_down = ($urandom_range(0, 7) == 0);
         hit          = ($urandom_range(0, 11) == 0);
         goal         = ($urandom_range(0, 47) == 0);
         btn_pause    = ($urandom_range(0, 31) == 0);
         cycle();
      end
      rst = 0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
